// File: rtl/stream_pkg.sv
// Shared types and default widths for the burst stream source.
package stream_pkg;

    typedef enum logic [0:0] {ST_IDLE, ST_STREAM} burst_state_e;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_LEN_WIDTH  = 8;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/stream_burst_source.sv
// Valid/ready burst initiator: turns a (start, len, stride) command into an
// arithmetic beat sequence with a last flag, accepting the next command on the last beat.
module stream_burst_source
    import stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_start,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_stride,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  bursts_done
);

    burst_state_e          r_state;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_stride;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_busy;
    logic [CNT_WIDTH-1:0]  r_done;

    logic w_out_fire;
    logic w_last_fire;
    logic w_cmd_ready;
    logic w_cmd_fire;

    // cmd_ready is the one combinational input->output path (via out_ready).
    assign w_out_fire  = r_valid && out_ready;
    assign w_last_fire = w_out_fire && r_last;
    assign w_cmd_ready = (r_state == ST_IDLE) || w_last_fire;
    assign w_cmd_fire  = cmd_valid && w_cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_data      <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_stride    <= cmd_stride;
                        r_data      <= cmd_start;
                        r_remaining <= cmd_len;
                        r_last      <= (cmd_len == '0);
                        r_valid     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_last_fire) begin
                        r_done <= r_done + CNT_WIDTH'(1);
                        // A command taken on the last beat reloads with zero bubble.
                        if (w_cmd_fire) begin
                            r_stride    <= cmd_stride;
                            r_data      <= cmd_start;
                            r_remaining <= cmd_len;
                            r_last      <= (cmd_len == '0);
                            r_valid     <= 1'b1;
                        end else begin
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_out_fire) begin
                        r_data      <= r_data + r_stride;
                        r_remaining <= r_remaining - LEN_WIDTH'(1);
                        r_last      <= (r_remaining == LEN_WIDTH'(1));
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign out_data    = r_data;
    assign out_last    = r_last;
    assign out_valid   = r_valid;
    assign busy        = r_busy;
    assign bursts_done = r_done;

endmodule

// File: tb/tb_stream_burst_source.sv
// Bench for stream_burst_source: directed scenarios plus random traffic scored
// against a queue of expected beats built from each accepted command.
module tb_stream_burst_source;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_start = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] cmd_stride = '0;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [15:0] bursts_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       q[$];
    logic [15:0] exp_done = '0;
    logic        m_ofire, m_lfire, m_cr;

    stream_burst_source dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .cmd_stride(cmd_stride),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .bursts_done(bursts_done)
    );

    always #5 clk = ~clk;

    // Scoreboard: every cycle, outputs must match the head of the expected-beat queue.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            q.delete();
            exp_done = '0;
        end else begin
            m_ofire = (q.size() > 0) && out_ready;
            m_lfire = m_ofire && q[0].last;
            m_cr    = (q.size() == 0) || m_lfire;
            checks++;
            if (out_valid !== (q.size() > 0)) begin
                errors++;
                $display("FAIL sb_valid t=%0t got %b exp %b", $time, out_valid, q.size() > 0);
            end
            checks++;
            if (busy !== (q.size() > 0)) begin
                errors++;
                $display("FAIL sb_busy t=%0t got %b exp %b", $time, busy, q.size() > 0);
            end
            checks++;
            if (cmd_ready !== m_cr) begin
                errors++;
                $display("FAIL sb_cmd_ready t=%0t got %b exp %b", $time, cmd_ready, m_cr);
            end
            checks++;
            if (bursts_done !== exp_done) begin
                errors++;
                $display("FAIL sb_bursts_done t=%0t got %0d exp %0d", $time, bursts_done, exp_done);
            end
            if (q.size() > 0) begin
                checks++;
                if (out_data !== q[0].data || out_last !== q[0].last) begin
                    errors++;
                    $display("FAIL sb_beat t=%0t got %h/%b exp %h/%b", $time,
                             out_data, out_last, q[0].data, q[0].last);
                end
            end
            if (m_ofire) void'(q.pop_front());
            if (m_lfire) exp_done = exp_done + 16'd1;
            if (cmd_valid && m_cr) begin
                for (int i = 0; i <= int'(cmd_len); i++)
                    q.push_back('{data: cmd_start + cmd_stride * 32'(i), last: (i == int'(cmd_len))});
            end
        end
    end

    task automatic drive(input logic cv, input logic [31:0] st, input logic [7:0] ln,
                         input logic [31:0] sd, input logic ordy);
        @(negedge clk);
        cmd_valid  = cv;
        cmd_start  = st;
        cmd_len    = ln;
        cmd_stride = sd;
        out_ready  = ordy;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 32'd0 ||
            busy !== 1'b0 || bursts_done !== 16'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got v=%b l=%b d=%h b=%b n=%0d cr=%b exp 0/0/0/0/0/1",
                     out_valid, out_last, out_data, busy, bursts_done, cmd_ready);
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        drive(1'b1, 32'h10, 8'd0, 32'd4, 1'b1);
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
        #3;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h10 || out_last !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_beat got v=%b d=%h l=%b b=%b exp 1/10/1/1",
                     out_valid, out_data, out_last, busy);
        end
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
        #3;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || bursts_done !== 16'd1) begin
            errors++;
            $display("FAIL single_after got b=%b v=%b n=%0d exp 0/0/1", busy, out_valid, bursts_done);
        end
    endtask

    task automatic test_basic_burst();
        do_reset();
        drive(1'b1, 32'h100, 8'd3, 32'h10, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
            #3;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h100 + 32'h10 * 32'(i) || out_last !== (i == 3)) begin
                errors++;
                $display("FAIL basic_beat%0d got v=%b d=%h l=%b exp 1/%h/%b", i,
                         out_valid, out_data, out_last, 32'h100 + 32'h10 * 32'(i), i == 3);
            end
        end
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
        #3;
        checks++;
        if (out_valid !== 1'b0 || bursts_done !== 16'd1) begin
            errors++;
            $display("FAIL basic_end got v=%b n=%0d exp 0/1", out_valid, bursts_done);
        end
    endtask

    task automatic test_backpressure();
        logic [6:0] pat;
        int fires;
        pat = 7'b1101001;   // bit i = out_ready in cycle i: 1,0,0,1,0,1,1
        fires = 0;
        do_reset();
        drive(1'b1, 32'h100, 8'd3, 32'h10, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 32'h0, 8'd0, 32'd0, pat[i]);
            #3;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'h100 + 32'h10 * 32'(fires) || out_last !== (fires == 3)) begin
                errors++;
                $display("FAIL bp_cycle%0d got v=%b d=%h l=%b exp 1/%h/%b", i,
                         out_valid, out_data, out_last, 32'h100 + 32'h10 * 32'(fires), fires == 3);
            end
            if (pat[i]) fires++;
        end
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b0);
        #3;
        checks++;
        if (out_valid !== 1'b0 || bursts_done !== 16'd1 || fires != 4) begin
            errors++;
            $display("FAIL bp_end got v=%b n=%0d fires=%0d exp 0/1/4", out_valid, bursts_done, fires);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d[6];
        exp_d = '{32'h100, 32'h110, 32'h120, 32'h130, 32'hA, 32'hB};
        do_reset();
        drive(1'b1, 32'h100, 8'd3, 32'h10, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(i < 4, 32'hA, 8'd1, 32'd1, 1'b1);
            #3;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 3 || i == 5) ||
                cmd_ready !== (i == 3 || i == 5)) begin
                errors++;
                $display("FAIL b2b_beat%0d got v=%b d=%h l=%b cr=%b exp 1/%h/%b/%b", i,
                         out_valid, out_data, out_last, cmd_ready, exp_d[i], i == 3 || i == 5, i == 3 || i == 5);
            end
        end
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
        #3;
        checks++;
        if (bursts_done !== 16'd2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got n=%0d v=%b exp 2/0", bursts_done, out_valid);
        end
    endtask

    task automatic test_wrap_max();
        do_reset();
        drive(1'b1, 32'hFFFF_FFFE, 8'hFF, 32'd1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
            #3;
            if (i == 2 || i == 254 || i == 255) begin
                checks++;
                if (out_data !== 32'hFFFF_FFFE + 32'(i) || out_last !== (i == 255) || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL wrap_beat%0d got d=%h l=%b v=%b exp %h/%b/1", i,
                             out_data, out_last, out_valid, 32'hFFFF_FFFE + 32'(i), i == 255);
                end
            end
        end
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
        #3;
        checks++;
        if (out_valid !== 1'b0 || bursts_done !== 16'd1) begin
            errors++;
            $display("FAIL wrap_end got v=%b n=%0d exp 0/1", out_valid, bursts_done);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        drive(1'b1, 32'h0, 8'd7, 32'd1, 1'b1);
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b0);
        #3;
        checks++;
        if (out_data !== 32'd2 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_beat2 got d=%h v=%b exp 2/1", out_data, out_valid);
        end
        // command presented during reset must be ignored
        @(negedge clk);
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_start = 32'h77;
        @(negedge clk);
        rst = 1'b0;
        cmd_valid = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || bursts_done !== 16'd0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b n=%0d cr=%b b=%b exp 0/0/1/0", out_valid, bursts_done, cmd_ready, busy);
        end
        drive(1'b1, 32'h55, 8'd1, 32'h3, 1'b1);
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
        #3;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h55 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_restart0 got v=%b d=%h l=%b exp 1/55/0", out_valid, out_data, out_last);
        end
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
        #3;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h58 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart1 got v=%b d=%h l=%b exp 1/58/1", out_valid, out_data, out_last);
        end
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
    endtask

    task automatic test_random();
        int budget;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 2) == 0), $urandom(),
                  ($urandom_range(0, 7) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 4)),
                  ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom(),
                  ($urandom_range(0, 3) != 0));
        end
        budget = 0;
        drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
        while (q.size() > 0 && budget < 1000) begin
            drive(1'b0, 32'h0, 8'd0, 32'd0, 1'b1);
            budget++;
        end
        #3;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL random_drain got v=%b b=%b after %0d cycles exp 0/0", out_valid, busy, budget);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_basic_burst();
        test_backpressure();
        test_back_to_back();
        test_wrap_max();
        test_reset_mid_burst();
        test_random();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
